// File: rtl/secuenciador_dosis_pkg.sv
// Shared definitions for the dosing sequencer: FSM states, colour indices
// and the default prescaler ratio (100 ms per dose unit at 50 MHz).
package secuenciador_dosis_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_R  = 3'd1,
    GAP_RG = 3'd2,
    RUN_G  = 3'd3,
    GAP_GB = 3'd4,
    RUN_B  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam int IDX_R = 0;
  localparam int IDX_G = 1;
  localparam int IDX_B = 2;

  localparam int TICK_DIV_DEFAULT = 5000000;

  function automatic logic [2:0] motor_of(input state_t s);
    case (s)
      RUN_R:   motor_of = 3'b001;
      RUN_G:   motor_of = 3'b010;
      RUN_B:   motor_of = 3'b100;
      default: motor_of = 3'b000;
    endcase
  endfunction

  function automatic logic is_run(input state_t s);
    return (s == RUN_R) || (s == RUN_G) || (s == RUN_B);
  endfunction

endpackage

// File: rtl/secuenciador_dosis_if.sv
// Control/status bundle between the system FSM, dose memory and the sequencer.
interface secuenciador_dosis_if #(
  parameter int W = 5
);
  logic         start;
  logic         abort;
  logic [W-1:0] ciclos_R;
  logic [W-1:0] ciclos_G;
  logic [W-1:0] ciclos_B;
  logic [2:0]   motores;
  logic [2:0]   flags;
  logic         busy;
  logic         done;
  logic [W-1:0] restante;

  modport master (
    output start, abort, ciclos_R, ciclos_G, ciclos_B,
    input  motores, flags, busy, done, restante
  );

  modport slave (
    input  start, abort, ciclos_R, ciclos_G, ciclos_B,
    output motores, flags, busy, done, restante
  );
endinterface

// File: rtl/secuenciador_dosis_prescaler_tick.sv
// Free-running divider emitting a one-cycle tick every TICK_DIV enabled cycles,
// with a synchronous clear so each new phase starts a fresh unit.
module prescaler_tick
  import secuenciador_dosis_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr || !en || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end
endmodule

// File: rtl/secuenciador_dosis.sv
// R -> G -> B pump sequencer: latches dose counts on start, runs each non-zero
// colour for count x TICK_DIV cycles with optional idle gaps in between.
module secuenciador_dosis
  import secuenciador_dosis_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int GAP_UNITS = 2,
  parameter int W         = 5
) (
  input logic               clk,
  input logic               reset,
  secuenciador_dosis_if.slave bus
);
  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS + 1) : 1;

  state_t         state, state_next;
  logic [W-1:0]   c_r, c_g, c_b, c_r_next, c_g_next, c_b_next;
  logic [W-1:0]   rest_q, rest_next;
  logic [GW-1:0]  gap_q, gap_next;
  logic [2:0]     flags_q, flags_next;
  logic [2:0]     motores_q;
  logic           busy_q, done_q;
  logic           tick, last_unit, pre_en, pre_clr;

  assign pre_en  = is_run(state) || (state == GAP_RG) || (state == GAP_GB);
  assign pre_clr = bus.abort || (state_next != state);

  prescaler_tick #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      c_r       <= '0;
      c_g       <= '0;
      c_b       <= '0;
      rest_q    <= '0;
      gap_q     <= '0;
      flags_q   <= '0;
      motores_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      c_r       <= c_r_next;
      c_g       <= c_g_next;
      c_b       <= c_b_next;
      rest_q    <= rest_next;
      gap_q     <= gap_next;
      flags_q   <= flags_next;
      motores_q <= motor_of(state_next);
      busy_q    <= (state_next != IDLE);
      done_q    <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    c_r_next   = c_r;
    c_g_next   = c_g;
    c_b_next   = c_b;
    rest_next  = rest_q;
    gap_next   = gap_q;
    flags_next = flags_q;
    last_unit  = tick && (rest_q == W'(1));

    if (bus.abort) begin
      state_next = IDLE;
      flags_next = '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          c_r_next   = bus.ciclos_R;
          c_g_next   = bus.ciclos_G;
          c_b_next   = bus.ciclos_B;
          flags_next = '0;
          // Leading zero-count colours are reported done at the moment they are skipped
          if (bus.ciclos_R != '0) begin
            state_next = RUN_R;
          end else if (bus.ciclos_G != '0) begin
            flags_next[IDX_R] = 1'b1;
            state_next = RUN_G;
          end else if (bus.ciclos_B != '0) begin
            flags_next[IDX_R] = 1'b1;
            flags_next[IDX_G] = 1'b1;
            state_next = RUN_B;
          end else begin
            flags_next = 3'b111;
            state_next = DONE;
          end
        end
        RUN_R: begin
          if (tick) rest_next = rest_q - W'(1);
          if (last_unit) begin
            flags_next[IDX_R] = 1'b1;
            if (c_g != '0) begin
              state_next = (GAP_UNITS > 0) ? GAP_RG : RUN_G;
            end else if (c_b != '0) begin
              flags_next[IDX_G] = 1'b1;
              state_next = (GAP_UNITS > 0) ? GAP_GB : RUN_B;
            end else begin
              flags_next[IDX_G] = 1'b1;
              flags_next[IDX_B] = 1'b1;
              state_next = DONE;
            end
          end
        end
        RUN_G: begin
          if (tick) rest_next = rest_q - W'(1);
          if (last_unit) begin
            flags_next[IDX_G] = 1'b1;
            if (c_b != '0) begin
              state_next = (GAP_UNITS > 0) ? GAP_GB : RUN_B;
            end else begin
              flags_next[IDX_B] = 1'b1;
              state_next = DONE;
            end
          end
        end
        RUN_B: begin
          if (tick) rest_next = rest_q - W'(1);
          if (last_unit) begin
            flags_next[IDX_B] = 1'b1;
            state_next = DONE;
          end
        end
        GAP_RG, GAP_GB: if (tick) begin
          gap_next = gap_q - GW'(1);
          if (gap_q == GW'(1)) state_next = (state == GAP_RG) ? RUN_G : RUN_B;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // Counters are reloaded on the edge that enters a new phase
    if (state_next != state) begin
      case (state_next)
        RUN_R:          rest_next = c_r_next;
        RUN_G:          rest_next = c_g_next;
        RUN_B:          rest_next = c_b_next;
        GAP_RG, GAP_GB: gap_next  = GW'(GAP_UNITS);
        default:        ;
      endcase
    end
    if (!is_run(state_next)) rest_next = '0;
  end

  assign bus.motores  = motores_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.restante = rest_q;
endmodule

// File: tb/tb_secuenciador_dosis.sv
// Directed bench for secuenciador_dosis: per-cycle expectations are queued
// when a sequence is started and compared on each falling clock edge.
module tb_secuenciador_dosis;
  localparam int TICK = 4;
  localparam int GAP  = 1;
  localparam int W    = 5;

  typedef struct packed {
    logic [2:0]   mot;
    logic [2:0]   fl;
    logic [W-1:0] rest;
    logic         dn;
    logic         bsy;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  secuenciador_dosis_if #(.W(W)) bus ();

  secuenciador_dosis #(
    .TICK_DIV  (TICK),
    .GAP_UNITS (GAP),
    .W         (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] mot, input logic [2:0] fl, input int rest,
                      input logic dn, input logic bsy);
    exp_t e;
    e.mot  = mot;
    e.fl   = fl;
    e.rest = W'(rest);
    e.dn   = dn;
    e.bsy  = bsy;
    sb.push_back(e);
  endtask

  // Reference timeline: every non-zero colour runs count*TICK cycles, gaps only
  // between two non-zero colours, then one DONE cycle and a return to idle.
  task automatic build_model(input int r, input int g, input int b);
    int         c[3];
    logic [2:0] fl;
    logic [2:0] onehot;
    bit         prev_nz;
    c[0] = r; c[1] = g; c[2] = b;
    fl = 3'b000;
    prev_nz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (c[i] == 0) begin
        fl[i] = 1'b1;
      end else begin
        if (prev_nz && GAP > 0)
          for (int k = 0; k < GAP * TICK; k++) push(3'b000, fl, 0, 1'b0, 1'b1);
        onehot = 3'b000;
        onehot[i] = 1'b1;
        for (int k = 0; k < c[i] * TICK; k++) push(onehot, fl, c[i] - k / TICK, 1'b0, 1'b1);
        fl[i] = 1'b1;
        prev_nz = 1'b1;
      end
    end
    push(3'b000, 3'b111, 0, 1'b1, 1'b1);
    push(3'b000, 3'b111, 0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("[TB] FAIL sb_underflow observed=empty expected=entry");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("motores",  bus.motores,  e.mot);
        check("flags",    bus.flags,    e.fl);
        check("restante", bus.restante, e.rest);
        check("done",     bus.done,     e.dn);
        check("busy",     bus.busy,     e.bsy);
      end
    end
  endtask

  task automatic apply_stimulus(input int r, input int g, input int b);
    bus.ciclos_R = W'(r);
    bus.ciclos_G = W'(g);
    bus.ciclos_B = W'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic abort_after(input int r, input int g, input int b, input int n);
    build_model(r, g, b);
    apply_stimulus(r, g, b);
    check_output(n);
    sb.delete();
    bus.abort = 1'b1;
    push(3'b000, 3'b000, 0, 1'b0, 1'b0);
    check_output(1);
    bus.abort = 1'b0;
    repeat (2) push(3'b000, 3'b000, 0, 1'b0, 1'b0);
    check_output(2);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ciclos_R = '0;
    bus.ciclos_G = '0;
    bus.ciclos_B = '0;
    repeat (2) @(negedge clk);
    check("rst_motores",  bus.motores,  0);
    check("rst_flags",    bus.flags,    0);
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_restante", bus.restante, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] full R/G/B sequence with gaps");
    build_model(2, 1, 3);
    apply_stimulus(2, 1, 3);
    check_output(sb.size());

    $display("[TB] single green colour, red and blue skipped");
    build_model(0, 2, 0);
    apply_stimulus(0, 2, 0);
    check_output(sb.size());

    $display("[TB] all counts zero");
    build_model(0, 0, 0);
    apply_stimulus(0, 0, 0);
    check_output(sb.size());

    $display("[TB] abort during red unit 2");
    abort_after(3, 0, 0, 6);

    $display("[TB] abort during green with red flag already set");
    abort_after(0, 3, 0, 6);

    $display("[TB] start while busy is ignored");
    build_model(2, 0, 0);
    apply_stimulus(2, 0, 0);
    check_output(3);
    apply_stimulus(9, 0, 0);
    check_output(sb.size());

    $display("[TB] asynchronous reset during green");
    build_model(1, 2, 0);
    apply_stimulus(1, 2, 0);
    check_output(11);
    sb.delete();
    #2 reset = 1'b0;
    #1;
    check("arst_motores",  bus.motores,  0);
    check("arst_flags",    bus.flags,    0);
    check("arst_busy",     bus.busy,     0);
    check("arst_done",     bus.done,     0);
    check("arst_restante", bus.restante, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    build_model(2, 0, 1);
    apply_stimulus(2, 0, 1);
    check_output(sb.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/secuenciador_dosis.md
Name: secuenciador_dosis

Overview:
- Dispensing sequencer directly downstream of the RGB dosage memory and the keypad enter synchroniser.
- On a start pulse it latches the three per-colour dose counts (R, G, B), in units of 100 ms. It then drives the three pump motors one at a time, in order R, then G, then B, each for its latched duration, with a fixed idle gap between colours.
- Reports per-colour completion flags to the system FSM and the remaining units to the display driver.

Parameters:
TICK_DIV, 5000000, clk cycles per dose unit (100 ms at 50 MHz); must be >= 2
GAP_UNITS, 2, dose units of all-motors-off pause between consecutive non-zero colours; 0 = no gap
W, 5, width of each dose count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle start pulse (synchronised enter)
abort  in  1  level; forces return to IDLE
ciclos_R  in  W  red dose units
ciclos_G  in  W  green dose units
ciclos_B  in  W  blue dose units
motores  out  3  one-hot pump enables: bit0 = R, bit1 = G, bit2 = B
flags  out  3  sticky done flags per colour, same bit order
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on entering DONE
restante  out  W  units left for the active colour; 0 outside RUN states

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low. While reset = 0, all outputs are 0, state = IDLE, the prescaler is 0 and all latched counts are 0.
- States: IDLE, RUN_R, GAP_RG, RUN_G, GAP_GB, RUN_B, DONE.
- IDLE:
  - start = 1 latches ciclos_R/G/B into internal registers cR/cG/cB in the same edge.
  - The next state is the first colour in order R, G, B whose latched count is non-zero.
  - If all three counts are 0: go straight to DONE and set flags = 3'b111.
  - start also clears flags before any new flags are set.
- Entering any RUN state:
  - Prescaler loads 0.
  - restante loads the colour's count.
  - The matching motores bit rises on the first cycle of the state, registered, so 1 cycle after the transition edge.
- Unit counting:
  - The prescaler counts 0 to TICK_DIV-1; each wrap is one unit tick.
  - Each tick decrements restante.
  - On the tick that takes restante from 1 to 0: motor off, set that colour's flag, leave the state.
  - Exact motor-on time = count × TICK_DIV cycles.
- Leaving a RUN state, with next = the next non-zero colour:
  - If a later colour is non-zero and GAP_UNITS > 0: enter the GAP state before it.
  - If a later colour is non-zero and GAP_UNITS = 0: enter its RUN state directly.
  - If no later non-zero colour exists: go to DONE.
  - Zero-count colours are skipped and their flags are set at the moment they are skipped.
- GAP states:
  - motores = 0.
  - Prescaler restarts from 0.
  - Lasts GAP_UNITS ticks, then the next RUN state is entered.
- DONE:
  - done = 1 for exactly one cycle.
  - busy stays high for that cycle.
  - Next state is IDLE; flags hold until the next start or abort.
- start while busy is ignored; latched counts are unaffected.
- abort = 1 in any state:
  - Next state is IDLE.
  - motores = 0, flags = 0, restante = 0, no done pulse.
  - abort has priority over start and over a simultaneous tick.
- Output invariants:
  - motores is never more than one-hot.
  - motores is 0 in IDLE, GAP and DONE.
  - Input counts may change freely after the latch without effect.
- Width rule: the prescaler is $clog2(TICK_DIV) bits. The count registers are W bits; the maximum dose is 2^W − 1 units, with no wrap.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - colour index constants IDX_R = 0, IDX_G = 1, IDX_B = 2;
  - default TICK_DIV.
- One natural sub-module: prescaler_tick.
  - Synchronous clear input and counter.
  - Emits a one-cycle tick every TICK_DIV cycles.
  - Reused by the top-level 100 ms clock path.

Test Plan (use TICK_DIV = 4, GAP_UNITS = 1):
1. R = 2, G = 1, B = 3, start → motores = 001 for 8 cycles, 000 for 4, 010 for 4, 000 for 4, 100 for 12. Then done pulses once, flags = 111, busy falls the cycle after done.
2. R = 0, G = 2, B = 0, start → R flag set immediately; motores = 010 for 8 cycles, no gaps; done; flags = 111.
3. R = G = B = 0, start → DONE on the next cycle, done pulse, flags = 111, motores never non-zero.
4. R = 3 running, abort asserted mid-unit 2 → next cycle motores = 000, flags = 000, restante = 0, busy = 0, no done pulse.
5. R = 2, start; change ciclos_R to 9 and pulse start again during RUN_R → R still runs 8 cycles total, the second start is ignored.
6. Assert reset low during RUN_G → motores, flags, busy and restante go to 0 asynchronously, before the next clk edge. Release reset, pulse start with new counts → a fresh sequence runs correctly.
